qar_gpio2: RTL and testbench

QAR_GPIO2 -- requirements
Module: qar_gpio2

---
 rtl/qar_gpio2.sv | 130 +++++++++++++
 tb/tb_qar_gpio2.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qar_gpio2.sv
// qar_gpio2: register-mapped GPIO with input synchronisers, per-pin debounce, edge/level interrupts and alternate-function muxing
module qar_gpio2 #(
  parameter int WIDTH       = 8,
  parameter int NUM_ALT     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   write_en,
  input  logic                                   read_en,
  input  logic [4:0]                             addr_word,
  input  logic [31:0]                            wdata,
  output logic [31:0]                            rdata,
  input  logic [WIDTH-1:0]                       gpio_in,
  input  logic [(NUM_ALT > 0 ? NUM_ALT : 1)-1:0] alt_in,
  output logic [WIDTH-1:0]                       gpio_out,
  output logic [WIDTH-1:0]                       gpio_dir,
  output logic                                   irq
);
  localparam logic [WIDTH-1:0] ALT_MASK = {WIDTH{1'b1}} >> (WIDTH - NUM_ALT);
  logic [WIDTH-1:0] dir_q, dir_d, out_q, out_d, irq_en_q, irq_en_d, irq_st_q, irq_st_d;
  logic [WIDTH-1:0] alt_sel_q, alt_sel_d, irq_rise_q, irq_rise_d, irq_fall_q, irq_fall_d;
  logic [WIDTH-1:0] irq_lvl_q, irq_lvl_d, db_en_q, db_en_d;
  logic [15:0] db_cyc_q, db_cyc_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0][15:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] db_q, db_d, dq_q, s, rise, fall, set_term, wd, alt_vec;
  logic [31:0] we, rd_val, rdata_q;
  logic [16:0] thresh;
  logic irq_q;
  logic unused_ok;
  assign unused_ok = ^{wdata, we, alt_in};
  assign wd = wdata[WIDTH-1:0];
  assign we = write_en ? (32'd1 << addr_word) : '0;
  assign s = sync_q[SYNC_STAGES-1];
  assign thresh = (db_cyc_q == 16'd0) ? 17'd1 : {1'b0, db_cyc_q};
  assign rise = db_q & ~dq_q;
  assign fall = ~db_q & dq_q;
  assign set_term = (irq_lvl_q & ((irq_rise_q & db_q) | (irq_fall_q & ~db_q))) |
                    (~irq_lvl_q & ((irq_rise_q & rise) | (irq_fall_q & fall)));
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    logic [16:0] inc;
    logic hit;
    assign inc = {1'b0, cnt_q[i]} + 17'd1;
    assign hit = (s[i] != db_q[i]) && (inc >= thresh);
    assign db_d[i] = db_en_q[i] ? (hit ? s[i] : db_q[i]) : s[i];
    assign cnt_d[i] = (!db_en_q[i] || s[i] == db_q[i] || hit) ? 16'd0 : inc[15:0];
  end
  for (genvar j = 0; j < WIDTH; j++) begin : g_alt
    if (j < NUM_ALT) begin : g_src
      assign alt_vec[j] = alt_in[j];
    end else begin : g_none
      assign alt_vec[j] = 1'b0;
    end
  end
  assign gpio_dir = dir_q;
  assign gpio_out = (out_q & ~alt_sel_q) | (alt_vec & alt_sel_q);
  assign rdata = rdata_q;
  assign irq = irq_q;
  // Register next-state from write decode; a same-cycle status set overrides W1C
  always_comb begin
    dir_d      = we[0] ? wd : dir_q;
    out_d      = we[1] ? wd : we[3] ? (out_q | wd) : we[4] ? (out_q & ~wd) : we[5] ? (out_q ^ wd) : out_q;
    irq_en_d   = we[6] ? wd : irq_en_q;
    irq_st_d   = (irq_st_q & ~(we[7] ? wd : '0)) | set_term;
    alt_sel_d  = we[8] ? (wd & ALT_MASK) : alt_sel_q;
    irq_rise_d = we[9] ? wd : irq_rise_q;
    irq_fall_d = we[10] ? wd : irq_fall_q;
    irq_lvl_d  = we[11] ? wd : irq_lvl_q;
    db_en_d    = we[12] ? wd : db_en_q;
    db_cyc_d   = we[13] ? wdata[15:0] : db_cyc_q;
  end
  // Read mux sees pre-write register values so a coincident write is not reflected
  always_comb begin
    rd_val = '0;
    case (addr_word)
      5'd0:  rd_val = 32'(dir_q);
      5'd1:  rd_val = 32'(out_q);
      5'd2:  rd_val = 32'(db_q);
      5'd6:  rd_val = 32'(irq_en_q);
      5'd7:  rd_val = 32'(irq_st_q);
      5'd8:  rd_val = 32'(alt_sel_q);
      5'd9:  rd_val = 32'(irq_rise_q);
      5'd10: rd_val = 32'(irq_fall_q);
      5'd11: rd_val = 32'(irq_lvl_q);
      5'd12: rd_val = 32'(db_en_q);
      5'd13: rd_val = 32'(db_cyc_q);
      5'd14: rd_val = 32'(s);
      default: ;
    endcase
  end
  // Control/status registers, synchroniser, debounce state, read data and irq
  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q      <= '0;
      out_q      <= '0;
      irq_en_q   <= '0;
      irq_st_q   <= '0;
      alt_sel_q  <= '0;
      irq_rise_q <= '1;
      irq_fall_q <= '0;
      irq_lvl_q  <= '0;
      db_en_q    <= '0;
      db_cyc_q   <= 16'd32;
      sync_q     <= '0;
      db_q       <= '0;
      dq_q       <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      out_q      <= out_d;
      irq_en_q   <= irq_en_d;
      irq_st_q   <= irq_st_d;
      alt_sel_q  <= alt_sel_d;
      irq_rise_q <= irq_rise_d;
      irq_fall_q <= irq_fall_d;
      irq_lvl_q  <= irq_lvl_d;
      db_en_q    <= db_en_d;
      db_cyc_q   <= db_cyc_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      db_q       <= db_d;
      dq_q       <= db_q;
      cnt_q      <= cnt_d;
      rdata_q    <= read_en ? rd_val : '0;
      irq_q      <= |(irq_st_q & irq_en_q);
    end
  end
endmodule

// File: tb/tb_qar_gpio2.sv
// tb_qar_gpio2: directed and randomized scoreboard bench for qar_gpio2 against a cycle-level reference model
module tb_qar_gpio2;
  localparam int W = 8;
  localparam int NA = 2;
  localparam int SS = 2;
  logic clk = 0, rst = 1, write_en = 0, read_en = 0;
  logic [4:0] addr_word = 0;
  logic [31:0] wdata = 0, rdata;
  logic [W-1:0] gpio_in = 0, gpio_out, gpio_dir;
  logic [NA-1:0] alt_in = 0;
  logic irq;
  int checks = 0, errors = 0;

  qar_gpio2 #(.WIDTH(W), .NUM_ALT(NA), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en), .addr_word(addr_word),
    .wdata(wdata), .rdata(rdata), .gpio_in(gpio_in), .alt_in(alt_in),
    .gpio_out(gpio_out), .gpio_dir(gpio_dir), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  logic [W-1:0] m_dir = 0, m_out = 0, m_ien = 0, m_st = 0, m_alt = 0, m_rise = '1, m_fall = 0, m_lvl = 0, m_dben = 0;
  logic [W-1:0] m_d = 0, m_dq = 0;
  logic [W-1:0] m_sync [SS];
  logic [15:0] m_dbc = 32;
  int m_cnt [W];
  logic m_irq = 0;
  bit m_rd = 0;
  logic [31:0] rq [$];

  function automatic logic [31:0] mreg(input int a);
    case (a)
      0: return 32'(m_dir);
      1: return 32'(m_out);
      2: return 32'(m_d);
      6: return 32'(m_ien);
      7: return 32'(m_st);
      8: return 32'(m_alt);
      9: return 32'(m_rise);
      10: return 32'(m_fall);
      11: return 32'(m_lvl);
      12: return 32'(m_dben);
      13: return 32'(m_dbc);
      14: return 32'(m_sync[SS-1]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_out();
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = (i < NA && m_alt[i]) ? alt_in[i] : m_out[i];
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic [W-1:0] s, nd, rs, fl, setv, w1c, wd;
    int thr;
    if (rst) begin
      m_dir = 0; m_out = 0; m_ien = 0; m_st = 0; m_alt = 0; m_rise = '1; m_fall = 0; m_lvl = 0;
      m_dben = 0; m_dbc = 32; m_d = 0; m_dq = 0; m_irq = 0; m_rd = 0;
      for (int k = 0; k < SS; k++) m_sync[k] = 0;
      for (int i = 0; i < W; i++) m_cnt[i] = 0;
    end else begin
      wd = wdata[W-1:0];
      m_rd = read_en;
      if (read_en) rq.push_back(mreg(addr_word));
      rs = m_d & ~m_dq;
      fl = ~m_d & m_dq;
      for (int i = 0; i < W; i++)
        setv[i] = m_lvl[i] ? ((m_rise[i] & m_d[i]) | (m_fall[i] & ~m_d[i])) : ((m_rise[i] & rs[i]) | (m_fall[i] & fl[i]));
      m_irq = |(m_st & m_ien);
      s = m_sync[SS-1];
      thr = (m_dbc == 0) ? 1 : int'(m_dbc);
      nd = m_d;
      for (int i = 0; i < W; i++) begin
        if (!m_dben[i]) begin
          nd[i] = s[i];
          m_cnt[i] = 0;
        end else if (s[i] == m_d[i]) m_cnt[i] = 0;
        else begin
          m_cnt[i]++;
          if (m_cnt[i] >= thr) begin
            nd[i] = s[i];
            m_cnt[i] = 0;
          end
        end
      end
      m_dq = m_d;
      m_d = nd;
      for (int k = SS - 1; k > 0; k--) m_sync[k] = m_sync[k-1];
      m_sync[0] = gpio_in;
      w1c = (write_en && addr_word == 7) ? wd : '0;
      m_st = (m_st & ~w1c) | setv;
      if (write_en)
        case (addr_word)
          0: m_dir = wd;
          1: m_out = wd;
          3: m_out = m_out | wd;
          4: m_out = m_out & ~wd;
          5: m_out = m_out ^ wd;
          6: m_ien = wd;
          8: m_alt = wd & W'((1 << NA) - 1);
          9: m_rise = wd;
          10: m_fall = wd;
          11: m_lvl = wd;
          12: m_dben = wd;
          13: m_dbc = wdata[15:0];
          default: ;
        endcase
    end
  end

  always @(posedge clk) begin : monitor
    #1;
    if (m_rd) begin
      if (rq.size() == 0) chk("rdata_queue_empty", rdata, 32'hxxxxxxxx);
      else chk("rdata", rdata, rq.pop_front());
    end else chk("rdata_idle", rdata, 32'd0);
    chk("gpio_out", 32'(gpio_out), 32'(exp_out()));
    chk("gpio_dir", 32'(gpio_dir), 32'(m_dir));
    chk("irq", 32'(irq), 32'(m_irq));
  end

  task automatic wr(input int a, input logic [31:0] d);
    addr_word = 5'(a);
    wdata = d;
    write_en = 1;
    @(negedge clk);
    write_en = 0;
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input logic [31:0] mask, input string nm);
    addr_word = 5'(a);
    read_en = 1;
    @(negedge clk);
    read_en = 0;
    chk(nm, rdata & mask, exp & mask);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_gpio_out", 32'(gpio_out), 0);
    chk("reset_irq", 32'(irq), 0);
    rst = 0;
    rd(9, 32'hFF, '1, "reset_irq_rise");
    rd(13, 32, '1, "reset_db_cycles");
    wr(0, 'hFF); wr(1, 'h0F); wr(3, 'h30); wr(4, 'h01); wr(5, 'h81);
    chk("out_ops_gpio_out", 32'(gpio_out), 32'hBF);
    chk("out_ops_gpio_dir", 32'(gpio_dir), 32'hFF);
    rd(1, 32'hBF, '1, "out_readback");
    rd(3, 0, '1, "wo_reads_zero");
    wr(1, 0); wr(8, 3); alt_in = 2'b10;
    @(negedge clk);
    chk("alt_gpio_out", 32'(gpio_out), 32'h02);
    wr(8, 'hFF);
    rd(8, 3, '1, "alt_sel_mask");
    addr_word = 1; wdata = 'h55; write_en = 1; read_en = 1;
    @(negedge clk);
    write_en = 0; read_en = 0;
    chk("rw_same_cycle_old", rdata, 0);
    rd(1, 'h55, '1, "rw_same_cycle_new");
    do_reset();
    wr(12, 1); wr(13, 4);
    gpio_in[0] = 1;
    repeat (3) @(negedge clk);
    gpio_in[0] = 0;
    repeat (8) @(negedge clk);
    rd(2, 0, 1, "db_short_pulse");
    gpio_in[0] = 1;
    repeat (10) @(negedge clk);
    rd(2, 1, 1, "db_long_pulse");
    rd(7, 1, '1, "db_rise_status");
    rd(14, 1, 1, "in_raw");
    wr(12, 0); wr(7, 1); wr(6, 1);
    gpio_in[0] = 0;
    repeat (6) @(negedge clk);
    chk("irq_idle", 32'(irq), 0);
    gpio_in[0] = 1;
    repeat (6) @(negedge clk);
    chk("irq_on_rise", 32'(irq), 1);
    wr(7, 1);
    @(negedge clk);
    chk("irq_after_w1c", 32'(irq), 0);
    rd(7, 0, 1, "status_after_w1c");
    gpio_in[0] = 0;
    repeat (6) @(negedge clk);
    gpio_in[0] = 1;
    repeat (3) @(negedge clk);
    wr(7, 1);
    rd(7, 1, 1, "set_beats_w1c");
    wr(11, 4); wr(9, 'hFB); wr(10, 4);
    repeat (3) @(negedge clk);
    wr(7, 4);
    rd(7, 4, 4, "level_reassert1");
    wr(7, 4);
    rd(7, 4, 4, "level_reassert2");
    wr(12, 'hFF); wr(13, 10);
    gpio_in = 'hA5;
    repeat (4) @(negedge clk);
    addr_word = 1; read_en = 1; rst = 1; gpio_in = 0;
    @(negedge clk);
    read_en = 0; rst = 0;
    chk("rst_mid_read", rdata, 0);
    chk("rst_gpio_out", 32'(gpio_out), 0);
    chk("rst_gpio_dir", 32'(gpio_dir), 0);
    repeat (4) @(negedge clk);
    chk("rst_no_irq", 32'(irq), 0);
    rd(0, 0, '1, "rst_dir"); rd(1, 0, '1, "rst_out"); rd(6, 0, '1, "rst_ien");
    rd(7, 0, '1, "rst_status"); rd(8, 0, '1, "rst_alt"); rd(9, 'hFF, '1, "rst_rise");
    rd(10, 0, '1, "rst_fall"); rd(11, 0, '1, "rst_level"); rd(12, 0, '1, "rst_db_en");
    rd(13, 32, '1, "rst_db_cycles"); rd(20, 0, '1, "reserved_20");
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) gpio_in = W'($urandom);
      if ($urandom_range(0, 7) == 0) alt_in = NA'($urandom);
      write_en = ($urandom_range(0, 9) < 3);
      read_en = ($urandom_range(0, 9) < 3);
      addr_word = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 15));
      wdata = (addr_word == 13) ? $urandom_range(0, 5) : $urandom;
      @(negedge clk);
    end
    rst = 0; write_en = 0; read_en = 0;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
